// File: rtl/rv_mdu_seq.sv
// Sequential RV32M multiply/divide unit: 32-step shift-add multiplier and restoring
// divider sharing one accumulator, with sign fix-up and single-cycle fast paths.
module rv_mdu_seq (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        mdu_req_i,
  input  logic [2:0]  mdu_op_i,
  input  logic [31:0] mdu_port_a_i,
  input  logic [31:0] mdu_port_b_i,
  input  logic        mdu_kill_i,
  output logic        mdu_stall_req_o,
  output logic [31:0] mdu_result_o,
  output logic        mdu_valid_o
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  counter_q, counter_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] result_q, result_d;
  logic        valid_q, valid_d;

  logic        a_signed, b_signed, a_neg, b_neg, is_div, overflow;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, div_shift, div_trial;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  always_comb begin
    a_signed  = (mdu_op_i != OP_MULHU) && (mdu_op_i != OP_DIVU) && (mdu_op_i != OP_REMU);
    b_signed  = a_signed && (mdu_op_i != OP_MULHSU);
    a_neg     = a_signed & mdu_port_a_i[31];
    b_neg     = b_signed & mdu_port_b_i[31];
    abs_a     = a_neg ? -mdu_port_a_i : mdu_port_a_i;
    abs_b     = b_neg ? -mdu_port_b_i : mdu_port_b_i;
    is_div    = mdu_op_i[2];
    overflow  = ((mdu_op_i == OP_DIV) || (mdu_op_i == OP_REM)) &&
                (mdu_port_a_i == 32'h8000_0000) && (mdu_port_b_i == 32'hFFFF_FFFF);
    // Multiplier sits in acc[31:0] and retires from the bottom; partial sum grows on top.
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    div_shift = {rem_q[31:0], acc_q[31]};
    div_trial = div_shift - {1'b0, mcand_q};
    prod_fix  = neg_q ? -acc_q : acc_q;
    quot_fix  = neg_q ? -acc_q[31:0] : acc_q[31:0];
    rem_fix   = neg_rem_q ? -rem_q[31:0] : rem_q[31:0];
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (mdu_req_i) begin
          op_d      = mdu_op_i;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (is_div && (mdu_port_b_i == 32'd0)) begin
            result_d = mdu_op_i[1] ? mdu_port_a_i : 32'hFFFF_FFFF;
            state_d  = DONE;
          end else if (overflow) begin
            result_d = mdu_op_i[1] ? 32'd0 : 32'h8000_0000;
            state_d  = DONE;
          end else begin
            acc_d     = {32'd0, is_div ? abs_a : abs_b};
            mcand_d   = is_div ? abs_b : abs_a;
            rem_d     = 33'd0;
            counter_d = 5'd31;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          if (!div_trial[32]) begin
            rem_d        = div_trial;
            acc_d[31:0]  = {acc_q[30:0], 1'b1};
          end else begin
            rem_d        = div_shift;
            acc_d[31:0]  = {acc_q[30:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        counter_d = counter_q - 5'd1;
        if (counter_q == 5'd0) state_d = SIGN;
      end
      SIGN: begin
        if (!op_q[2]) result_d = (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
        else          result_d = op_q[1] ? rem_fix : quot_fix;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // A flush aborts whatever is in flight and leaves the last result untouched.
    if (mdu_kill_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      counter_q <= 5'd0;
      op_q      <= 3'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= 64'd0;
      mcand_q   <= 32'd0;
      rem_q     <= 33'd0;
      result_q  <= 32'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
    end
  end

  assign mdu_valid_o     = valid_q & ~mdu_kill_i;
  assign mdu_result_o    = result_q;
  assign mdu_stall_req_o = mdu_req_i & ~mdu_valid_o & ~arst_i;

endmodule

// File: tb/tb_rv_mdu_seq.sv
// Directed and random bench for rv_mdu_seq, checked against a plain-arithmetic
// model of the RV32M result rules and the documented latencies.
module tb_rv_mdu_seq;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        req = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        kill = 1'b0;
  logic        stall;
  logic [31:0] result;
  logic        valid;

  int n_checks = 0;
  int n_fail   = 0;

  rv_mdu_seq dut (
    .clk_i          (clk),
    .arst_i         (arst),
    .mdu_req_i      (req),
    .mdu_op_i       (op),
    .mdu_port_a_i   (a),
    .mdu_port_b_i   (b),
    .mdu_kill_i     (kill),
    .mdu_stall_req_o(stall),
    .mdu_result_o   (result),
    .mdu_valid_o    (valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f_op, input logic [31:0] fa, input logic [31:0] fb);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(fa));
    sb  = longint'($signed(fb));
    ua  = longint'({32'd0, fa});
    ub  = longint'({32'd0, fb});
    ovf = (fa == 32'h8000_0000) && (fb == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (f_op)
      MUL:    begin p = sa * sb; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV:    begin
                if (fb == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
              end
      DIVU:   return (fb == 0) ? 32'hFFFF_FFFF : fa / fb;
      REM:    begin
                if (fb == 0) return fa;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
              end
      default: return (fb == 0) ? fa : fa % fb;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f_op, input logic [31:0] fa, input logic [31:0] fb);
    if (f_op[2] && fb == 0) return 1;
    if ((f_op == DIV || f_op == REM) && fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one op in the current (IDLE) cycle, wait for the strobe, check stall,
  // latency and result, then check the strobe lasts one cycle.
  task automatic run_op(input string tag, input logic [2:0] t_op, input logic [31:0] ta,
                        input logic [31:0] tb, input logic [31:0] exp, input int exp_lat,
                        input bit keep);
    int cyc = 0;
    bit got = 0;
    op = t_op; a = ta; b = tb; req = 1'b1;
    #1;
    while (!got && cyc <= 40) begin
      if (valid) got = 1;
      else begin
        if (cyc == 0 || cyc == exp_lat - 1) chk({tag, "_stall"}, stall, 1'b1);
        tick();
        cyc++;
      end
    end
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_stall_at_valid"}, stall, 1'b0);
    $display("op=%0d a=%08h b=%08h result=%08h latency=%0d %s", t_op, ta, tb, result, cyc, tag);
    if (!keep) req = 1'b0;
    tick();
    chk({tag, "_strobe"}, valid, 1'b0);
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] ra, rb;
    logic [31:0] specials [4];
    specials[0] = 32'd0; specials[1] = 32'h8000_0000;
    specials[2] = 32'hFFFF_FFFF; specials[3] = 32'd1;

    // reset state, with a request pending that must not raise stall
    req = 1'b1;
    #2;
    chk("rst_result", result, 32'd0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_stall", stall, 1'b0);
    req = 1'b0;
    tick(); tick();
    arst = 1'b0;
    tick();

    run_op("mul_neg",  MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    run_op("mulhu",    MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    run_op("mulh",     MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
    run_op("mulhsu",   MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, 0);
    run_op("div_neg",  DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0);
    run_op("rem_neg",  REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0);
    run_op("divu",     DIVU,   32'd100,       32'd7,         32'd14,        34, 0);
    run_op("remu",     REMU,   32'd100,       32'd7,         32'd2,         34, 0);
    run_op("div0",     DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("rem0",     REM,    32'd5,         32'd0,         32'd5,         1,  0);
    run_op("div_ovf",  DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
    run_op("rem_ovf",  REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  0);

    // kill mid-CALC, then a fresh MUL issued in the following cycle
    op = DIV; a = 32'd1000; b = 32'd3; req = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) tick();
    kill = 1'b1;
    #1;
    chk("kill_valid", valid, 1'b0);
    tick();
    kill = 1'b0;
    run_op("mul_after_kill", MUL, 32'd3, 32'd4, 32'd12, 34, 0);

    // kill during the DONE cycle suppresses the strobe
    op = DIV; a = 32'd5; b = 32'd0; req = 1'b1;
    #1;
    tick();
    chk("done_valid", valid, 1'b1);
    kill = 1'b1;
    #1;
    chk("kill_done_valid", valid, 1'b0);
    req = 1'b0;
    tick();
    kill = 1'b0;
    chk("kill_done_result_kept", result, 32'hFFFF_FFFF);

    // asynchronous reset mid-CALC
    op = MUL; a = 32'h1234; b = 32'h5678; req = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) tick();
    #2;
    arst = 1'b1;
    #1;
    chk("arst_result", result, 32'd0);
    chk("arst_valid", valid, 1'b0);
    chk("arst_stall", stall, 1'b0);
    req = 1'b0;
    tick(); tick();
    arst = 1'b0;
    tick();

    // back-to-back: request held through DONE, next op accepted right after
    run_op("b2b_mul",  MUL,  32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 34, 1);
    run_op("b2b_divu", DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 34, 0);

    for (int i = 0; i < 40; i++) begin
      r_op = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = specials[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) rb = specials[$urandom_range(0, 3)];
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(1, 31);
      run_op($sformatf("rnd%0d", i), r_op, ra, rb, model(r_op, ra, rb), latency(r_op, ra, rb), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
